// File: rtl/tl_source_shrinker.sv
// tl_source_shrinker: allocates narrow device TileLink source IDs for a wide host source space.
// Define TL_SOURCE_SHRINKER_OCCUPANCY_EN to add occupancy_o/full_o slot-usage outputs.
module tl_source_shrinker #(
  parameter int HostSourceWidth = 8,
  parameter int DeviceSourceWidth = 2,
  parameter int SinkWidth = 1,
  parameter int AddrWidth = 56,
  parameter int DataWidth = 64,
  parameter int MaxSize = 6,
  localparam int sz_w = $clog2(MaxSize + 1),
  localparam int a_rest = AddrWidth + DataWidth / 8 + DataWidth + 1,
  localparam int d_rest = SinkWidth + DataWidth + 2,
  localparam int haw = 6 + sz_w + HostSourceWidth + a_rest,
  localparam int daw = 6 + sz_w + DeviceSourceWidth + a_rest,
  localparam int hdw = 5 + sz_w + HostSourceWidth + d_rest,
  localparam int ddw = 5 + sz_w + DeviceSourceWidth + d_rest,
  localparam int hbw = 5 + sz_w + HostSourceWidth + a_rest,
  localparam int dbw = 5 + sz_w + DeviceSourceWidth + a_rest,
  localparam int hcw = 6 + sz_w + HostSourceWidth + AddrWidth + DataWidth + 1,
  localparam int dcw = 6 + sz_w + DeviceSourceWidth + AddrWidth + DataWidth + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 host_a_valid,
  output logic                 host_a_ready,
  input  logic [haw-1:0]       host_a,
  output logic                 host_d_valid,
  input  logic                 host_d_ready,
  output logic [hdw-1:0]       host_d,
  output logic                 host_b_valid,
  input  logic                 host_b_ready,
  output logic [hbw-1:0]       host_b,
  input  logic                 host_c_valid,
  output logic                 host_c_ready,
  input  logic [hcw-1:0]       host_c,
  input  logic                 host_e_valid,
  output logic                 host_e_ready,
  input  logic [SinkWidth-1:0] host_e,
  output logic                 device_a_valid,
  input  logic                 device_a_ready,
  output logic [daw-1:0]       device_a,
  input  logic                 device_d_valid,
  output logic                 device_d_ready,
  input  logic [ddw-1:0]       device_d,
  input  logic                 device_b_valid,
  output logic                 device_b_ready,
  input  logic [dbw-1:0]       device_b,
  output logic                 device_c_valid,
  input  logic                 device_c_ready,
  output logic [dcw-1:0]       device_c,
  output logic                 device_e_valid,
  input  logic                 device_e_ready,
  output logic [SinkWidth-1:0] device_e
`ifdef TL_SOURCE_SHRINKER_OCCUPANCY_EN
  ,
  output logic [DeviceSourceWidth:0] occupancy_o,
  output logic                       full_o
`endif
);
  localparam int n_slots = 1 << DeviceSourceWidth;
  localparam int lb = $clog2(DataWidth / 8);
  localparam int cw = MaxSize > lb ? MaxSize - lb : 1;
  logic [n_slots-1:0] r_valid;
  logic [HostSourceWidth-1:0] r_src [n_slots];
  logic [cw-1:0] r_a_cnt, r_d_cnt, w_a_len, w_d_len;
  logic [DeviceSourceWidth-1:0] r_a_idx, w_free_idx, w_a_src, w_d_src;
  logic w_free_found, w_a_first, w_a_ok, w_a_fire, w_alloc, w_d_fire, w_d_last, w_unused;
  function automatic logic [cw-1:0] beats_m1(input logic [sz_w-1:0] size, input logic data);
    return data && int'(size) > lb ? cw'((1 << (int'(size) - lb)) - 1) : '0;
  endfunction
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx = '0;
    for (int i = n_slots - 1; i >= 0; i--)
      if (!r_valid[i]) begin
        w_free_found = 1'b1;
        w_free_idx = DeviceSourceWidth'(i);
      end
  end
  // Only the first beat of an A message needs a free slot; later beats reuse the held index.
  assign w_a_first = r_a_cnt == '0;
  assign w_a_ok = rst_ni && (!w_a_first || w_free_found);
  assign w_a_src = w_a_first ? w_free_idx : r_a_idx;
  assign device_a_valid = w_a_ok && host_a_valid;
  assign host_a_ready = w_a_ok && device_a_ready;
  assign device_a = {host_a[haw-1 -: 6+sz_w], w_a_src, host_a[a_rest-1:0]};
  assign w_a_fire = host_a_valid && host_a_ready;
  assign w_alloc = w_a_fire && w_a_first;
  assign w_a_len = beats_m1(host_a[haw-7 -: sz_w], !host_a[haw-1]);
  assign w_d_src = device_d[d_rest +: DeviceSourceWidth];
  assign host_d_valid = rst_ni && device_d_valid;
  assign device_d_ready = rst_ni && host_d_ready;
  assign host_d = {device_d[ddw-1 -: 5+sz_w], r_src[w_d_src], device_d[d_rest-1:0]};
  assign w_d_fire = device_d_valid && device_d_ready;
  assign w_d_len = beats_m1(device_d[ddw-6 -: sz_w], device_d[ddw-2 -: 2] == 2'b01);
  assign w_d_last = r_d_cnt == '0 ? w_d_len == '0 : r_d_cnt == cw'(1);
  // Clear precedes set so a slot freed and reallocated in one cycle ends valid.
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      r_valid <= '0;
      r_a_cnt <= '0;
      r_d_cnt <= '0;
      r_a_idx <= '0;
    end else begin
      if (w_d_fire) begin
        r_d_cnt <= r_d_cnt == '0 ? w_d_len : r_d_cnt - cw'(1);
        if (w_d_last) r_valid[w_d_src] <= 1'b0;
      end
      if (w_a_fire) r_a_cnt <= w_a_first ? w_a_len : r_a_cnt - cw'(1);
      if (w_alloc) begin
        r_valid[w_free_idx] <= 1'b1;
        r_a_idx <= w_free_idx;
      end
    end
  always_ff @(posedge clk_i)
    if (w_alloc) r_src[w_free_idx] <= host_a[a_rest +: HostSourceWidth];
`ifdef TL_SOURCE_SHRINKER_OCCUPANCY_EN
  localparam int ow = DeviceSourceWidth + 1;
  logic [DeviceSourceWidth:0] r_occ;
  logic w_free;
  assign w_free = w_d_fire && w_d_last && r_valid[w_d_src];
  always_ff @(posedge clk_i)
    if (!rst_ni) r_occ <= '0;
    else r_occ <= r_occ + ow'(w_alloc) - ow'(w_free);
  assign occupancy_o = r_occ;
  assign full_o = &r_valid;
`endif
  assign host_b_valid = 1'b0;
  assign host_b = '0;
  assign host_c_ready = 1'b0;
  assign host_e_ready = 1'b0;
  assign device_b_ready = 1'b1;
  assign device_c_valid = 1'b0;
  assign device_c = '0;
  assign device_e_valid = 1'b0;
  assign device_e = '0;
  assign w_unused = ^{host_b_ready, host_c_valid, host_c, host_e_valid, host_e,
                      device_b_valid, device_b, device_c_ready, device_e_ready};
endmodule

// File: tb/tb_tl_source_shrinker.sv
// tb_tl_source_shrinker: directed checks of slot allocation, bursts, freeing and reset.
module tb_tl_source_shrinker;
  localparam int haw = 146, daw = 140, hdw = 83, ddw = 77;
  localparam int hbw = 145, dbw = 139, hcw = 138, dcw = 132;
  logic clk_i = 1'b0, rst_ni;
  logic host_a_valid, host_a_ready, host_d_valid, host_d_ready;
  logic [haw-1:0] host_a;
  logic [hdw-1:0] host_d;
  logic host_b_valid, host_b_ready, host_c_valid, host_c_ready, host_e_valid, host_e_ready;
  logic [hbw-1:0] host_b;
  logic [hcw-1:0] host_c;
  logic [0:0] host_e, device_e;
  logic device_a_valid, device_a_ready, device_d_valid, device_d_ready;
  logic [daw-1:0] device_a;
  logic [ddw-1:0] device_d;
  logic device_b_valid, device_b_ready, device_c_valid, device_c_ready, device_e_valid, device_e_ready;
  logic [dbw-1:0] device_b;
  logic [dcw-1:0] device_c;
`ifdef TL_SOURCE_SHRINKER_OCCUPANCY_EN
  logic [2:0] occupancy_o;
  logic full_o;
`endif
  int n_vec = 0, n_err = 0;
  tl_source_shrinker dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .host_a_valid(host_a_valid), .host_a_ready(host_a_ready), .host_a(host_a),
    .host_d_valid(host_d_valid), .host_d_ready(host_d_ready), .host_d(host_d),
    .host_b_valid(host_b_valid), .host_b_ready(host_b_ready), .host_b(host_b),
    .host_c_valid(host_c_valid), .host_c_ready(host_c_ready), .host_c(host_c),
    .host_e_valid(host_e_valid), .host_e_ready(host_e_ready), .host_e(host_e),
    .device_a_valid(device_a_valid), .device_a_ready(device_a_ready), .device_a(device_a),
    .device_d_valid(device_d_valid), .device_d_ready(device_d_ready), .device_d(device_d),
    .device_b_valid(device_b_valid), .device_b_ready(device_b_ready), .device_b(device_b),
    .device_c_valid(device_c_valid), .device_c_ready(device_c_ready), .device_c(device_c),
    .device_e_valid(device_e_valid), .device_e_ready(device_e_ready), .device_e(device_e)
`ifdef TL_SOURCE_SHRINKER_OCCUPANCY_EN
    , .occupancy_o(occupancy_o), .full_o(full_o)
`endif
  );
  always #5 clk_i = ~clk_i;
  function automatic logic [haw-1:0] mk_ha(logic [2:0] op, logic [2:0] sz, logic [7:0] src, logic [63:0] d);
    return {op, 3'd0, sz, src, 56'h00_1234_5678_9abc, 8'hff, d, 1'b0};
  endfunction
  function automatic logic [daw-1:0] mk_da(logic [2:0] op, logic [2:0] sz, logic [1:0] src, logic [63:0] d);
    return {op, 3'd0, sz, src, 56'h00_1234_5678_9abc, 8'hff, d, 1'b0};
  endfunction
  function automatic logic [hdw-1:0] mk_hd(logic [2:0] op, logic [2:0] sz, logic [7:0] src, logic [63:0] d);
    return {op, 2'd0, sz, src, 1'b0, 1'b0, d, 1'b0};
  endfunction
  function automatic logic [ddw-1:0] mk_dd(logic [2:0] op, logic [2:0] sz, logic [1:0] src, logic [63:0] d);
    return {op, 2'd0, sz, src, 1'b0, 1'b0, d, 1'b0};
  endfunction
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  initial begin
    {host_b_ready, host_c_valid, host_e_valid, device_b_valid, device_c_ready, device_e_ready} = '0;
    host_c = '0;
    host_e = '0;
    device_b = '0;
    rst_ni = 1'b0;
    host_a_valid = 1'b1;
    host_a = mk_ha(3'd4, 3'd3, 8'h01, 64'd0);
    device_a_ready = 1'b1;
    device_d_valid = 1'b1;
    device_d = mk_dd(3'd1, 3'd3, 2'd0, 64'd0);
    host_d_ready = 1'b1;
    tick;
    tick;
    check("rst_host_a_ready", host_a_ready, 0);
    check("rst_device_a_valid", device_a_valid, 0);
    check("rst_host_d_valid", host_d_valid, 0);
    check("rst_device_d_ready", device_d_ready, 0);
`ifdef TL_SOURCE_SHRINKER_OCCUPANCY_EN
    check("rst_occupancy", occupancy_o, 0);
`endif
    check("tieoff_ctrl", {host_b_valid, host_c_ready, host_e_ready, device_b_ready, device_c_valid, device_e_valid}, 6'b000100);
    check("tieoff_payload", |{host_b, device_c, device_e}, 0);
    rst_ni = 1'b1;
    host_a_valid = 1'b0;
    device_d_valid = 1'b0;
    tick;
    host_a = mk_ha(3'd4, 3'd3, 8'h5a, 64'hdead);
    host_a_valid = 1'b1;
    #1;
    check("get_device_a", device_a, mk_da(3'd4, 3'd3, 2'd0, 64'hdead));
    check("get_valid", device_a_valid, 1);
    check("get_ready", host_a_ready, 1);
    tick;
    host_a_valid = 1'b0;
    device_d = mk_dd(3'd1, 3'd3, 2'd0, 64'hcafe);
    device_d_valid = 1'b1;
    #1;
    check("ackd_host_d", host_d, mk_hd(3'd1, 3'd3, 8'h5a, 64'hcafe));
    check("ackd_valid", host_d_valid, 1);
    tick;
    device_d_valid = 1'b0;
    host_a_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      host_a = mk_ha(3'd4, 3'd3, 8'h10 + 8'(i), 64'd0);
      #1;
      check("fill_device_a", device_a, mk_da(3'd4, 3'd3, 2'(i), 64'd0));
      check("fill_ready", host_a_ready, 1);
      tick;
    end
`ifdef TL_SOURCE_SHRINKER_OCCUPANCY_EN
    check("full_occupancy", occupancy_o, 4);
    check("full_flag", full_o, 1);
`endif
    host_a = mk_ha(3'd4, 3'd3, 8'h14, 64'd0);
    #1;
    check("stall_ready", host_a_ready, 0);
    check("stall_valid", device_a_valid, 0);
    tick;
    check("stall_ready_2", host_a_ready, 0);
    device_d = mk_dd(3'd1, 3'd3, 2'd1, 64'd7);
    device_d_valid = 1'b1;
    #1;
    check("free1_host_d", host_d, mk_hd(3'd1, 3'd3, 8'h11, 64'd7));
    check("same_cycle_block", host_a_ready, 0);
    tick;
    device_d_valid = 1'b0;
    #1;
    check("reuse_ready", host_a_ready, 1);
    check("reuse_device_a", device_a, mk_da(3'd4, 3'd3, 2'd1, 64'd0));
    tick;
    host_a = mk_ha(3'd4, 3'd3, 8'h20, 64'd0);
    for (int b = 0; b < 4; b++) begin
      device_d = mk_dd(3'd1, 3'd5, 2'd2, 64'(b));
      device_d_valid = 1'b1;
      #1;
      check("burst_d_host_d", host_d, mk_hd(3'd1, 3'd5, 8'h12, 64'(b)));
      check("burst_d_slot_held", host_a_ready, 0);
      tick;
    end
    device_d_valid = 1'b0;
    #1;
    check("burst_d_freed", host_a_ready, 1);
    check("burst_d_realloc", device_a, mk_da(3'd4, 3'd3, 2'd2, 64'd0));
    tick;
    host_a_valid = 1'b0;
    device_d = mk_dd(3'd0, 3'd6, 2'd3, 64'd0);
    device_d_valid = 1'b1;
    #1;
    check("ack_nodata_3", host_d, mk_hd(3'd0, 3'd6, 8'h13, 64'd0));
    tick;
    device_d = mk_dd(3'd0, 3'd3, 2'd0, 64'd0);
    #1;
    check("ack_nodata_0", host_d, mk_hd(3'd0, 3'd3, 8'h10, 64'd0));
    tick;
    device_d_valid = 1'b0;
    host_a_valid = 1'b1;
    for (int b = 0; b < 8; b++) begin
      host_a = mk_ha(3'd0, 3'd6, 8'h77, 64'(b));
      #1;
      check("put_device_a", device_a, mk_da(3'd0, 3'd6, 2'd0, 64'(b)));
      check("put_ready", host_a_ready, 1);
      tick;
    end
    host_a = mk_ha(3'd4, 3'd3, 8'h30, 64'd0);
    #1;
    check("after_put_device_a", device_a, mk_da(3'd4, 3'd3, 2'd3, 64'd0));
    tick;
    host_a_valid = 1'b0;
    device_d = mk_dd(3'd0, 3'd3, 2'd3, 64'd0);
    device_d_valid = 1'b1;
    #1;
    check("free3_host_d", host_d, mk_hd(3'd0, 3'd3, 8'h30, 64'd0));
    tick;
    device_d = mk_dd(3'd0, 3'd3, 2'd2, 64'd0);
    #1;
    check("free2_host_d", host_d, mk_hd(3'd0, 3'd3, 8'h20, 64'd0));
    tick;
    device_d_valid = 1'b0;
    host_a_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      host_a = mk_ha(3'd0, 3'd6, 8'h88, 64'(b));
      #1;
      check("pre_rst_put", device_a, mk_da(3'd0, 3'd6, 2'd2, 64'(b)));
      tick;
    end
`ifdef TL_SOURCE_SHRINKER_OCCUPANCY_EN
    check("pre_rst_occupancy", occupancy_o, 3);
`endif
    rst_ni = 1'b0;
    host_a_valid = 1'b0;
    tick;
    rst_ni = 1'b1;
`ifdef TL_SOURCE_SHRINKER_OCCUPANCY_EN
    check("post_rst_occupancy", occupancy_o, 0);
`endif
    host_a = mk_ha(3'd4, 3'd3, 8'h99, 64'd0);
    host_a_valid = 1'b1;
    #1;
    check("post_rst_device_a", device_a, mk_da(3'd4, 3'd3, 2'd0, 64'd0));
    check("post_rst_ready", host_a_ready, 1);
    tick;
    host_a_valid = 1'b0;
    device_d = mk_dd(3'd1, 3'd3, 2'd0, 64'd5);
    device_d_valid = 1'b1;
    #1;
    check("post_rst_host_d", host_d, mk_hd(3'd1, 3'd3, 8'h99, 64'd5));
    tick;
    device_d_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
